// File: rtl/npc_imem_pkg.sv
// Shared types and constants for the NPC instruction-memory responder.
package npc_imem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } imem_state_t;

  localparam logic [31:0]  IMEM_BASE = 32'h8000_0000;
  localparam int unsigned  LAT_CNT_W = 3;

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request / instruction response channel between the IFU and the instruction memory.
interface imem_responder_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/imem_array.sv
// Synchronous-write / synchronous-read instruction word array; a same-edge read returns the old word.
module imem_array #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  wen,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  ren,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (wen) r_mem[waddr] <= wdata;
    if (ren) rdata <= r_mem[raddr];
  end

endmodule

// File: rtl/imem_responder.sv
// Fixed-latency instruction fetch responder: one outstanding request, range/alignment
// checked against BASE, data returned from an internal loader-filled array.
module imem_responder
  import npc_imem_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       DEPTH_LOG2 = 12,
  parameter int unsigned       LATENCY    = 2,
  parameter logic [ADDR_W-1:0] BASE       = ADDR_W'(IMEM_BASE)
) (
  input  logic                  clk,
  input  logic                  rst,
  imem_responder_if.slave       bus,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [DATA_W-1:0]     ld_data
);

  if (LATENCY < 1 || LATENCY > 7) begin : g_bad_latency
    $error("imem_responder: LATENCY must be in 1..7");
  end
  if (BASE[1:0] != 2'b00) begin : g_bad_base
    $error("imem_responder: BASE must be word aligned");
  end

  imem_state_t           r_state, w_state_nxt;
  logic [LAT_CNT_W-1:0]  r_lat_cnt, w_lat_cnt_nxt;
  logic [ADDR_W-1:0]     r_addr, w_addr_nxt, w_chk_addr;
  logic [ADDR_W-3:0]     w_off;
  logic                  w_enter, w_err;
  logic                  r_err, r_data_ok;
  logic [DATA_W-1:0]     w_rdata;

  always_comb begin
    w_state_nxt   = r_state;
    w_lat_cnt_nxt = r_lat_cnt;
    w_addr_nxt    = r_addr;
    w_enter       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_addr_nxt = bus.req_addr;
          if (LATENCY == 1) begin
            w_state_nxt = RESP;
            w_enter     = 1'b1;
          end else begin
            w_state_nxt   = WAIT;
            w_lat_cnt_nxt = LAT_CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        w_lat_cnt_nxt = r_lat_cnt - 1'b1;
        if (r_lat_cnt == LAT_CNT_W'(1)) begin
          w_state_nxt = RESP;
          w_enter     = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // With LATENCY==1 RESP is entered on the accept edge, so the check must see req_addr directly.
  // BASE is word aligned, so subtracting only the word-index bits equals off[ADDR_W-1:2].
  assign w_chk_addr = (r_state == IDLE) ? bus.req_addr : r_addr;
  assign w_off      = w_chk_addr[ADDR_W-1:2] - BASE[ADDR_W-1:2];
  assign w_err      = (w_chk_addr[1:0] != 2'b00) || (w_off[ADDR_W-3:DEPTH_LOG2] != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_lat_cnt <= '0;
      r_addr    <= '0;
      r_err     <= 1'b0;
      r_data_ok <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_lat_cnt <= w_lat_cnt_nxt;
      r_addr    <= w_addr_nxt;
      if (w_enter) begin
        r_err     <= w_err;
        r_data_ok <= !w_err;
      end
    end
  end

  imem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .wen   (ld_en),
    .waddr (ld_addr),
    .wdata (ld_data),
    .ren   (w_enter),
    .raddr (w_off[DEPTH_LOG2-1:0]),
    .rdata (w_rdata)
  );

  // The array read register has no reset; r_data_ok forces zero data after reset and on errors.
  assign bus.req_ready = (r_state == IDLE);
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_err   = r_err;
  assign bus.rsp_data  = r_data_ok ? w_rdata : '0;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: LATENCY 2, 1 and 7 instances sharing clock, reset and loader.
module tb_imem_responder;

  localparam int LATS [3] = '{2, 1, 7};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_en = 1'b0;
  logic [11:0] ld_addr = '0;
  logic [31:0] ld_data = '0;

  logic        v_req_valid [3];
  logic [31:0] v_req_addr  [3];
  logic        v_rsp_ready [3];
  logic        w_req_ready [3];
  logic        w_rsp_valid [3];
  logic        w_rsp_err   [3];
  logic [31:0] w_rsp_data  [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    imem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    assign bus.req_valid  = v_req_valid[g];
    assign bus.req_addr   = v_req_addr[g];
    assign bus.rsp_ready  = v_rsp_ready[g];
    assign w_req_ready[g] = bus.req_ready;
    assign w_rsp_valid[g] = bus.rsp_valid;
    assign w_rsp_err[g]   = bus.rsp_err;
    assign w_rsp_data[g]  = bus.rsp_data;

    imem_responder #(.LATENCY(LATS[g])) u_dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .ld_en   (ld_en),
      .ld_addr (ld_addr),
      .ld_data (ld_data)
    );
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    int          hold;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  vec_t vecs [7];
  exp_t sb_q [$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [11:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic fetch(input int k, input logic [31:0] addr, input logic [31:0] ed,
                       input logic ee, input int hold, input bit wr_entry);
    int   n;
    int   bad;
    exp_t e;
    n = 0;
    while (!w_req_ready[k] && n < 20) begin tick(); n++; end
    chk("req_ready_idle", w_req_ready[k], 1);
    v_req_valid[k] = 1'b1;
    v_req_addr[k]  = addr;
    tick();
    v_req_valid[k] = 1'b0;
    sb_q.push_back('{data: ed, err: ee});
    n   = 1;
    bad = 0;
    while (!w_rsp_valid[k] && n < 20) begin
      if (w_req_ready[k]) bad++;
      if (wr_entry && n == LATS[k] - 1) begin
        ld_en = 1'b1; ld_addr = '0; ld_data = 32'hDEADBEEF;
      end
      tick();
      ld_en = 1'b0;
      n++;
    end
    chk("latency", n, LATS[k]);
    chk("req_ready_busy", bad, 0);
    chk("req_ready_resp", w_req_ready[k], 0);
    chk("sb_depth", sb_q.size(), 1);
    e = sb_q.pop_front();
    chk("rsp_data", w_rsp_data[k], e.data);
    chk("rsp_err", w_rsp_err[k], e.err);
    if (hold > 0) begin
      bad = 0;
      for (int i = 0; i < hold; i++) begin
        tick();
        if (w_rsp_valid[k] !== 1'b1 || w_rsp_data[k] !== e.data ||
            w_rsp_err[k] !== e.err || w_req_ready[k] !== 1'b0) bad++;
      end
      chk("hold_stable", bad, 0);
    end
    v_rsp_ready[k] = 1'b1;
    tick();
    v_rsp_ready[k] = 1'b0;
    chk("rsp_valid_clr", w_rsp_valid[k], 0);
    chk("req_ready_back", w_req_ready[k], 1);
    chk("data_kept", {w_rsp_err[k], w_rsp_data[k]}, {e.err, e.data});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stale;
    for (int i = 0; i < 3; i++) begin
      v_req_valid[i] = 1'b0; v_req_addr[i] = '0; v_rsp_ready[i] = 1'b0;
    end
    vecs[0] = '{32'h8000_0000, 32'h0000_0413, 1'b0, 0};
    vecs[1] = '{32'h8000_0004, 32'h0010_0073, 1'b0, 0};
    vecs[2] = '{32'h8000_0002, 32'h0000_0000, 1'b1, 0};
    vecs[3] = '{32'h7FFF_FFFC, 32'h0000_0000, 1'b1, 0};
    vecs[4] = '{32'h8000_4000, 32'h0000_0000, 1'b1, 0};
    vecs[5] = '{32'h8000_3FFC, 32'hCAFE_F00D, 1'b0, 5};
    vecs[6] = '{32'h8000_1000, 32'h1234_5678, 1'b0, 0};

    #1 rst = 1'b1;
    #1;
    chk("rst_req_ready", w_req_ready[0], 1);
    chk("rst_rsp_valid", w_rsp_valid[0], 0);
    chk("rst_rsp_data", w_rsp_data[0], 0);
    chk("rst_rsp_err", w_rsp_err[0], 0);
    tick(); tick();
    rst = 1'b0;

    load(12'd0,    32'h0000_0413);
    load(12'd1,    32'h0010_0073);
    load(12'd1024, 32'h1234_5678);
    load(12'd4095, 32'hCAFE_F00D);

    for (int i = 0; i < 7; i++)
      fetch(0, vecs[i].addr, vecs[i].data, vecs[i].err, vecs[i].hold, 1'b0);

    fetch(1, 32'h8000_0004, 32'h0010_0073, 1'b0, 0, 1'b0);
    fetch(1, 32'h8000_0006, 32'h0000_0000, 1'b1, 0, 1'b0);
    fetch(2, 32'h8000_3FFC, 32'hCAFE_F00D, 1'b0, 0, 1'b0);

    fetch(0, 32'h8000_0000, 32'h0000_0413, 1'b0, 0, 1'b1);
    fetch(0, 32'h8000_0000, 32'hDEADBEEF, 1'b0, 0, 1'b0);

    // Reset while the LATENCY=7 instance is mid-wait.
    v_req_valid[2] = 1'b1;
    v_req_addr[2]  = 32'h8000_0004;
    tick();
    v_req_valid[2] = 1'b0;
    tick(); tick();
    chk("mid_wait_busy", w_req_ready[2], 0);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", w_rsp_valid[2], 0);
    chk("async_rst_ready", w_req_ready[2], 1);
    chk("async_rst_data", w_rsp_data[2], 0);
    tick();
    rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (w_rsp_valid[2] !== 1'b0 || w_req_ready[2] !== 1'b1) stale++;
    end
    chk("no_stale_rsp", stale, 0);
    fetch(2, 32'h8000_0000, 32'hDEADBEEF, 1'b0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
